// File: rtl/fetch_pkg.sv
// Shared definitions for the instruction fetch unit: FSM state encoding and
// default address width / reset PC.
package fetch_pkg;

   localparam int          ADDR_W_DEF   = 16;
   localparam logic [15:0] RESET_PC_DEF = 16'h0000;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      WAIT = 2'd1,
      DONE = 2'd2
   } fetch_state_t;

endpackage

// File: rtl/fetch_if.sv
// Signal bundle between the fetch unit, the control unit and instruction memory.
// The slave modport is the fetch unit; master is the control/memory side.
interface fetch_if
   import fetch_pkg::*;
#(
   parameter int ADDR_W = ADDR_W_DEF
);

   // Memory handshake: mem_req stays high with mem_addr stable until the
   // first cycle in which mem_valid is high; the read completes on that
   // rising edge (ir_we marks it) and mem_req drops on the next cycle.
   logic              fetch_start;
   logic              pc_load;
   logic [ADDR_W-1:0] pc_load_val;
   logic              mem_req;
   logic [ADDR_W-1:0] mem_addr;
   logic              mem_valid;
   logic              ir_we;
   logic              fetch_done;
   logic [ADDR_W-1:0] pc_out;
   logic              fault;
   fetch_state_t      state;

   modport master (
      output fetch_start,
      output pc_load,
      output pc_load_val,
      output mem_valid,
      input  mem_req,
      input  mem_addr,
      input  ir_we,
      input  fetch_done,
      input  pc_out,
      input  fault,
      input  state
   );

   modport slave (
      input  fetch_start,
      input  pc_load,
      input  pc_load_val,
      input  mem_valid,
      output mem_req,
      output mem_addr,
      output ir_we,
      output fetch_done,
      output pc_out,
      output fault,
      output state
   );

endinterface

// File: rtl/pc_counter.sv
// Program counter: asynchronous reset to RESET_PC, load has priority over
// increment, increment wraps modulo 2^ADDR_W.
module pc_counter #(
   parameter int                ADDR_W   = 16,
   parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              load,
   input  logic [ADDR_W-1:0] load_val,
   input  logic              inc,
   output logic [ADDR_W-1:0] pc
);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pc <= RESET_PC;
      end else if (load) begin
         pc <= load_val;
      end else if (inc) begin
         pc <= pc + ADDR_W'(1);
      end
   end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch unit: IDLE -> WAIT -> DONE sequencer driving one memory
// read per fetch_start. Optional WAIT timeout enabled by FETCH_TIMEOUT_EN.
module fetch_unit
   import fetch_pkg::*;
#(
   parameter int                ADDR_W         = ADDR_W_DEF,
   parameter logic [ADDR_W-1:0] RESET_PC       = ADDR_W'(RESET_PC_DEF),
   parameter int                TIMEOUT_CYCLES = 255
) (
   input  logic    clk,
   input  logic    rst,
   fetch_if.slave  bus
);

   fetch_state_t      state;
   fetch_state_t      state_nxt;
   logic              timeout;
   logic              pc_ld;
   logic              pc_inc;
   logic [ADDR_W-1:0] pc;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE: begin
            if (bus.fetch_start) state_nxt = WAIT;
         end
         WAIT: begin
            if (bus.mem_valid) begin
               state_nxt = DONE;
            end else if (timeout) begin
               state_nxt = IDLE;
            end
         end
         DONE:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // Load is applied on the same edge that leaves IDLE, so a simultaneous
   // fetch_start reads from the new target.
   assign pc_ld  = (state == IDLE) && bus.pc_load;
   assign pc_inc = (state == WAIT) && bus.mem_valid;

   pc_counter #(
      .ADDR_W   (ADDR_W),
      .RESET_PC (RESET_PC)
   ) u_pc (
      .clk      (clk),
      .rst      (rst),
      .load     (pc_ld),
      .load_val (bus.pc_load_val),
      .inc      (pc_inc),
      .pc       (pc)
   );

   // mem_req and fetch_done decode the state register only.
   assign bus.mem_req    = (state == WAIT);
   assign bus.fetch_done = (state == DONE);
   assign bus.ir_we      = pc_inc;
   assign bus.mem_addr   = pc;
   assign bus.pc_out     = pc;
   assign bus.state      = state;

`ifdef FETCH_TIMEOUT_EN
   localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

   logic [CNT_W-1:0] wait_cnt;
   logic             fault_q;

   // wait_cnt holds the number of WAIT cycles already spent without data;
   // the timeout edge is the TIMEOUT_CYCLES-th such cycle.
   assign timeout = (state == WAIT) && !bus.mem_valid &&
                    (wait_cnt == CNT_W'(TIMEOUT_CYCLES - 1));

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wait_cnt <= '0;
         fault_q  <= 1'b0;
      end else begin
         if ((state == WAIT) && !bus.mem_valid && !timeout) begin
            wait_cnt <= wait_cnt + CNT_W'(1);
         end else begin
            wait_cnt <= '0;
         end
         if (timeout) begin
            fault_q <= 1'b1;
         end
      end
   end

   assign bus.fault = fault_q;
`else
   logic unused_timeout_cfg;

   assign timeout            = 1'b0;
   assign bus.fault          = 1'b0;
   assign unused_timeout_cfg = |TIMEOUT_CYCLES;
`endif

endmodule
